// File: rtl/control_sequencer_pkg.sv
// Shared constants and types for the hardwired control unit:
// opcodes, FSM state encoding, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_NOP, C_HALT
    } instr_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_in;
        logic       lo_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       c_out;
        logic       read;
        logic       write;
        logic       run;
        logic       illegal_op;
        logic [4:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the single-bus datapath.
// master = sequencer side, slave = datapath / environment side.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Mem_Done;
    logic        Stop;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        Read, Write;
    logic [4:0]  alu_op;
    logic        Run;
    logic        illegal_op;

    modport master (
        input  IR, Mem_Done, Stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output Read, Write, alu_op, Run, illegal_op
    );

    modport slave (
        output IR, Mem_Done, Stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  Read, Write, alu_op, Run, illegal_op
    );
endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational opcode classifier; undefined opcodes map to the nop class
// with the illegal flag raised.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode_i,
    output instr_class_t class_o,
    output logic         illegal_o
);

    always_comb begin
        class_o   = C_NOP;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_LD:   class_o = C_LD;
            OP_LDI:  class_o = C_LDI;
            OP_ST:   class_o = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
                     class_o = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:
                     class_o = C_IMM;
            OP_DIV, OP_MUL:
                     class_o = C_MULDIV;
            OP_NEG, OP_NOT:
                     class_o = C_UNARY;
            OP_NOP:  class_o = C_NOP;
            OP_HALT: class_o = C_HALT;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: steps fetch T0-T2 and execute T3-T7, stalls on
// memory steps until Mem_Done, and parks in PAUSE/HALT between instructions.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    control_sequencer_if.master bus
);

    state_t       state_q, state_d;
    instr_class_t cls;
    logic         illegal;
    logic [4:0]   opcode;
    ctrl_t        ctrl;
    state_t       boundary;

    assign opcode = bus.IR[OPC_MSB:OPC_LSB];

    opcode_decoder u_decoder (
        .opcode_i  (opcode),
        .class_o   (cls),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop is only honoured at instruction boundaries.
    assign boundary = bus.Stop ? S_PAUSE : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = bus.Mem_Done ? S_T2 : S_T1;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    C_HALT:  state_d = S_HALT;
                    C_NOP:   state_d = boundary;
                    default: state_d = S_T4;
                endcase
            end
            S_T4:    state_d = (cls == C_UNARY) ? boundary : S_T5;
            S_T5: begin
                case (cls)
                    C_MULDIV, C_LD, C_ST: state_d = S_T6;
                    default:              state_d = boundary;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD:    state_d = bus.Mem_Done ? S_T7 : S_T6;
                    C_ST:    state_d = S_T7;
                    default: state_d = boundary;
                endcase
            end
            S_T7: begin
                if (cls == C_ST && !bus.Mem_Done) begin
                    state_d = S_T7;
                end else begin
                    state_d = boundary;
                end
            end
            S_PAUSE: state_d = bus.Stop ? S_PAUSE : S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state_q != S_RST) && (state_q != S_PAUSE) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
            end
            S_T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU3, C_MULDIV, C_IMM: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    C_UNARY: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    C_NOP:   ctrl.illegal_op = illegal;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_ALU3, C_MULDIV: begin
                        ctrl.grc    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_UNARY: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    C_IMM: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                    end
                    C_LDI, C_LD, C_ST: begin
                        // Effective address: base register plus constant.
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = OP_ADD;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                case (cls)
                    C_ALU3, C_IMM, C_LDI: begin
                        ctrl.gra  = 1'b1;
                        ctrl.r_in = 1'b1;
                    end
                    C_MULDIV:   ctrl.lo_in  = 1'b1;
                    C_LD, C_ST: ctrl.mar_in = 1'b1;
                    default:    ctrl.zlow_out = 1'b0;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_MULDIV: begin
                        ctrl.zhigh_out = 1'b1;
                        ctrl.hi_in     = 1'b1;
                    end
                    C_LD: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    C_ST:    ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.PCout      = ctrl.pc_out;
    assign bus.PCin       = ctrl.pc_in;
    assign bus.IncPC      = ctrl.inc_pc;
    assign bus.MARin      = ctrl.mar_in;
    assign bus.MDRin      = ctrl.mdr_in;
    assign bus.MDRout     = ctrl.mdr_out;
    assign bus.IRin       = ctrl.ir_in;
    assign bus.Yin        = ctrl.y_in;
    assign bus.Zin        = ctrl.z_in;
    assign bus.Zlowout    = ctrl.zlow_out;
    assign bus.Zhighout   = ctrl.zhigh_out;
    assign bus.HIin       = ctrl.hi_in;
    assign bus.LOin       = ctrl.lo_in;
    assign bus.Gra        = ctrl.gra;
    assign bus.Grb        = ctrl.grb;
    assign bus.Grc        = ctrl.grc;
    assign bus.Rin        = ctrl.r_in;
    assign bus.Rout       = ctrl.r_out;
    assign bus.BAout      = ctrl.ba_out;
    assign bus.Cout       = ctrl.c_out;
    assign bus.Read       = ctrl.read;
    assign bus.Write      = ctrl.write;
    assign bus.Run        = ctrl.run;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.alu_op     = ctrl.alu_op;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the single-bus datapath. It steps the fetch/decode/execute phases T0..Tn and drives every datapath strobe (PCout, MARin, Zlowout, Rin, …) one step per clock. It decodes the opcode from the datapath's IR and stalls on memory. It sits directly upstream of the datapath and replaces hand-sequenced bench stimulus.

## Interface
- Parameters
  - none (opcode, ALU-code and field positions are fixed package constants)
- Ports
  - Clock  in  1  system clock; all state changes on the rising edge
  - Reset  in  1  synchronous, active-high
  - IR  in  32  instruction register contents; opcode IR[31:27]
  - Mem_Done  in  1  memory handshake; the current Read/Write completes on the edge it is 1
  - Stop  in  1  request pause at the next instruction boundary
  - PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes
  - Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and constant strobes
  - Read, Write  out  1 each  memory request, held during a wait
  - alu_op  out  5  ALU operation code; equals opcode for ALU ops, ADD (00011) for address computation, 0 otherwise
  - Run  out  1  high while executing
  - illegal_op  out  1  one-cycle pulse on an undefined opcode

## Operation
- Moore FSM: every output is decoded from the state register, plus the IR opcode in execute states. There are no combinational paths from Mem_Done or Stop to outputs.
- States: RST, T0..T7, PAUSE, HALT.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin; holds until Mem_Done
  - T2: MDRout, IRin
- Execute, starting at T3:
  - 3-reg ALU ops (add, sub, and, or, ror, rol, shr, shra, shl):
    - T3: Grb, Rout, Yin
    - T4: Grc, Rout, alu_op, Zin
    - T5: Zlowout, Gra, Rin
  - mul/div:
    - T3, T4: as for 3-reg ALU ops
    - T5: Zlowout, LOin
    - T6: Zhighout, HIin
  - neg/not:
    - T3: Grb, Rout, alu_op, Zin
    - T4: Zlowout, Gra, Rin
  - addi/andi/ori:
    - T3: Grb, Rout, Yin
    - T4: Cout, alu_op, Zin
    - T5: Zlowout, Gra, Rin
  - ldi:
    - T3: Grb, BAout, Yin
    - T4: Cout, alu_op=ADD, Zin
    - T5: Zlowout, Gra, Rin
  - ld:
    - T3–T4: as for ldi
    - T5: Zlowout, MARin
    - T6: Read, MDRin; waits
    - T7: MDRout, Gra, Rin
  - st:
    - T3–T5: as for ld
    - T6: Gra, Rout, MDRin
    - T7: Write; waits
  - nop: T3 only, with no outputs asserted.
  - halt: T3 goes to HALT.
  - Undefined opcode: T3 pulses illegal_op, then acts as nop.
- After an instruction's last step the FSM goes to T0, or to PAUSE if Stop=1 on that edge.
- PAUSE: all strobes 0, Run=0. Returns to T0 on the first edge with Stop=0.
- HALT: all strobes 0, Run=0. Only Reset exits.

## Timing
- Reset forces state RST on the next edge:
  - In RST all outputs are 0, including Run.
  - RST goes to T0 on the first edge with Reset=0; Run=1 from that T0.
- Reset dominates every other input, including mid-wait and during PAUSE or HALT. Any in-flight Read or Write drops the cycle after Reset is sampled.
- Each non-memory step lasts exactly one cycle. The datapath samples strobes on the edge that advances the state.
- Memory steps (T1; T6 of ld; T7 of st):
  - Read or Write stays high while Mem_Done=0.
  - The state advances on the edge where Mem_Done=1, with minimum length one cycle.
  - Mem_Done outside a memory step is ignored.
- Stop arriving during a memory wait has no effect until the instruction boundary.
- Stop=1 at the same time as halt decode: HALT wins.
- Instruction latency with Mem_Done=1 throughout, T0 to next T0:
  - nop: 4 cycles
  - neg/not: 5 cycles
  - ALU, immediate and ldi: 6 cycles
  - mul/div: 7 cycles
  - ld/st: 8 cycles
  - each memory-wait cycle adds one.

## Structure
- Shared package cpu_ctrl_pkg:
  - opcode localparams: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, nop 11010, halt 11011
  - state encoding
  - instruction-class enum
- Sub-module opcode_decoder: combinational IR[31:27] → instruction class plus illegal flag. The sequencer is the only consumer.

## Test plan
- Reset:
  - Stimulus: Reset=1 for 2 cycles mid-ld, during T6 with Mem_Done=0.
  - Response: next cycle all outputs are 0 and Run=0; T0 follows one cycle after Reset falls, with PCout=MARin=IncPC=Zin=1.
- add R1,R2,R3:
  - Stimulus: IR=0x18918000, Mem_Done=1.
  - Response: exactly 6 cycles; T4 shows Grc=Rout=Zin=1 with alu_op=00011; T5 shows Zlowout=Gra=Rin=1.
- mul:
  - Stimulus: IR=0x801A0000.
  - Response: T5 has LOin=1 and Zlowout=1; T6 has HIin=1 and Zhighout=1; 7 cycles total.
- ld R2,0x65(R1) with stall:
  - Stimulus: IR=0x01080065, Mem_Done held 0 for 3 cycles in T6.
  - Response: Read=MDRin=1 for 4 cycles; T7 then asserts MDRout=Gra=Rin=1.
- halt and Stop:
  - halt: IR=0xD8000000 → Run falls after T3 and stays low; IR changes are ignored.
  - Stop: Stop=1 during an add → PAUSE at the boundary; T0 follows one cycle after Stop falls.
- Undefined opcode:
  - Stimulus: IR=0xF8000000.
  - Response: illegal_op=1 for exactly one cycle in T3, then T0.
